// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module  : decode_stage
// Brief   : RV32I ID stage: control decode, 32x32 register file with bypass,
//           immediate generation and the ID/EX pipeline register.
// Rev     : 1.0
// ============================================================================
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  input  logic [31:0] ResultW,
  output logic        RegWriteE,
  output logic        ALUSrcE,
  output logic        MemWriteE,
  output logic        ResultSrcE,
  output logic        BranchE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  RS1E,
  output logic [4:0]  RS2E,
  output logic [4:0]  RDE
);

  localparam logic [6:0] c_op_lw    = 7'b0000011;
  localparam logic [6:0] c_op_sw    = 7'b0100011;
  localparam logic [6:0] c_op_rtype = 7'b0110011;
  localparam logic [6:0] c_op_beq   = 7'b1100011;
  localparam logic [6:0] c_op_ialu  = 7'b0010011;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic        w_regwrite;
  logic [1:0]  w_immsrc;
  logic        w_alusrc;
  logic        w_memwrite;
  logic        w_resultsrc;
  logic        w_branch;
  logic [1:0]  w_aluop;
  logic [2:0]  w_aluctl;
  logic [31:0] w_imm;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;
  logic        w_wr_en;
  logic [31:0] r_rf [0:31];

  assign w_opcode = InstrD[6:0];
  assign w_funct3 = InstrD[14:12];
  assign w_rs1    = InstrD[19:15];
  assign w_rs2    = InstrD[24:20];
  assign w_rd     = InstrD[11:7];

  always_comb begin
    w_regwrite  = 1'b0;
    w_immsrc    = 2'b00;
    w_alusrc    = 1'b0;
    w_memwrite  = 1'b0;
    w_resultsrc = 1'b0;
    w_branch    = 1'b0;
    w_aluop     = 2'b00;
    case (w_opcode)
      c_op_lw: begin
        w_regwrite  = 1'b1;
        w_alusrc    = 1'b1;
        w_resultsrc = 1'b1;
      end
      c_op_sw: begin
        w_immsrc   = 2'b01;
        w_alusrc   = 1'b1;
        w_memwrite = 1'b1;
      end
      c_op_rtype: begin
        w_regwrite = 1'b1;
        w_aluop    = 2'b10;
      end
      c_op_beq: begin
        w_immsrc = 2'b10;
        w_branch = 1'b1;
        w_aluop  = 2'b01;
      end
      c_op_ialu: begin
        w_regwrite = 1'b1;
        w_alusrc   = 1'b1;
        w_aluop    = 2'b10;
      end
      default: ;
    endcase
  end

  // Subtract only for R-type with funct7[5] set; addi never subtracts.
  always_comb begin
    w_aluctl = 3'b000;
    case (w_aluop)
      2'b01: w_aluctl = 3'b001;
      2'b10: begin
        case (w_funct3)
          3'b000:  w_aluctl = ({w_opcode[5], InstrD[30]} == 2'b11) ? 3'b001 : 3'b000;
          3'b010:  w_aluctl = 3'b101;
          3'b110:  w_aluctl = 3'b011;
          3'b111:  w_aluctl = 3'b010;
          default: w_aluctl = 3'b000;
        endcase
      end
      default: w_aluctl = 3'b000;
    endcase
  end

  always_comb begin
    w_imm = 32'd0;
    case (w_immsrc)
      2'b00:   w_imm = {{20{InstrD[31]}}, InstrD[31:20]};
      2'b01:   w_imm = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      2'b10:   w_imm = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      default: w_imm = 32'd0;
    endcase
  end

  assign w_wr_en = RegWriteW && (RDW != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_rf[i] <= 32'd0;
      end
    end else if (w_wr_en) begin
      r_rf[RDW] <= ResultW;
    end
  end

  // Write-through bypass so the ID/EX register sees this cycle's writeback.
  always_comb begin
    w_rd1 = 32'd0;
    w_rd2 = 32'd0;
    if (w_rs1 != 5'd0) begin
      w_rd1 = (w_wr_en && (RDW == w_rs1)) ? ResultW : r_rf[w_rs1];
    end
    if (w_rs2 != 5'd0) begin
      w_rd2 = (w_wr_en && (RDW == w_rs2)) ? ResultW : r_rf[w_rs2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      MemWriteE   <= 1'b0;
      ResultSrcE  <= 1'b0;
      BranchE     <= 1'b0;
      ALUControlE <= 3'b000;
      RD1E        <= 32'd0;
      RD2E        <= 32'd0;
      ImmExtE     <= 32'd0;
      PCE         <= 32'd0;
      PCPlus4E    <= 32'd0;
      RS1E        <= 5'd0;
      RS2E        <= 5'd0;
      RDE         <= 5'd0;
    end else begin
      RegWriteE   <= w_regwrite;
      ALUSrcE     <= w_alusrc;
      MemWriteE   <= w_memwrite;
      ResultSrcE  <= w_resultsrc;
      BranchE     <= w_branch;
      ALUControlE <= w_aluctl;
      RD1E        <= w_rd1;
      RD2E        <= w_rd2;
      ImmExtE     <= w_imm;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      RS1E        <= w_rs1;
      RS2E        <= w_rs2;
      RDE         <= w_rd;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_decode_stage
// Brief   : Scoreboard bench for decode_stage with a reference decode model.
// Rev     : 1.0
// ============================================================================
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW;
  logic [4:0]  RDW;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  RS1E, RS2E, RDE;

  typedef struct packed {
    logic        regwrite;
    logic        alusrc;
    logic        memwrite;
    logic        resultsrc;
    logic        branch;
    logic [2:0]  aluctl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_rf [32];
  int          n_checks = 0;
  int          n_errors = 0;

  decode_stage u_dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RS1E(RS1E), .RS2E(RS2E), .RDE(RDE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    check("RegWriteE",   {31'd0, RegWriteE},   {31'd0, e.regwrite});
    check("ALUSrcE",     {31'd0, ALUSrcE},     {31'd0, e.alusrc});
    check("MemWriteE",   {31'd0, MemWriteE},   {31'd0, e.memwrite});
    check("ResultSrcE",  {31'd0, ResultSrcE},  {31'd0, e.resultsrc});
    check("BranchE",     {31'd0, BranchE},     {31'd0, e.branch});
    check("ALUControlE", {29'd0, ALUControlE}, {29'd0, e.aluctl});
    check("RD1E",        RD1E,                 e.rd1);
    check("RD2E",        RD2E,                 e.rd2);
    check("ImmExtE",     ImmExtE,              e.imm);
    check("PCE",         PCE,                  e.pc);
    check("PCPlus4E",    PCPlus4E,             e.pc4);
    check("RS1E",        {27'd0, RS1E},        {27'd0, e.rs1});
    check("RS2E",        {27'd0, RS2E},        {27'd0, e.rs2});
    check("RDE",         {27'd0, RDE},         {27'd0, e.rd});
  endtask

  function automatic logic [31:0] rf_read(input logic [4:0] a, input logic wen,
                                          input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (wen && wa == a) return wd;
    return m_rf[a];
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic wen, input logic [4:0] wa, input logic [31:0] wd);
    exp_t       e;
    logic [1:0] isrc;
    logic [1:0] aop;
    e = '0;
    isrc = 2'd0;
    aop = 2'd0;
    case (ins[6:0])
      7'b0000011: begin e.regwrite = 1; e.alusrc = 1; e.resultsrc = 1; end
      7'b0100011: begin isrc = 2'd1; e.alusrc = 1; e.memwrite = 1; end
      7'b0110011: begin e.regwrite = 1; aop = 2'd2; end
      7'b1100011: begin isrc = 2'd2; e.branch = 1; aop = 2'd1; end
      7'b0010011: begin e.regwrite = 1; e.alusrc = 1; aop = 2'd2; end
      default: ;
    endcase
    if (aop == 2'd1) e.aluctl = 3'b001;
    else if (aop == 2'd2) begin
      case (ins[14:12])
        3'b000:  e.aluctl = (ins[5] && ins[30]) ? 3'b001 : 3'b000;
        3'b010:  e.aluctl = 3'b101;
        3'b110:  e.aluctl = 3'b011;
        3'b111:  e.aluctl = 3'b010;
        default: e.aluctl = 3'b000;
      endcase
    end
    case (isrc)
      2'd0: e.imm = 32'($signed(ins[31:20]));
      2'd1: e.imm = 32'($signed({ins[31:25], ins[11:7]}));
      2'd2: e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      default: e.imm = 32'd0;
    endcase
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    e.rd1 = rf_read(e.rs1, wen, wa, wd);
    e.rd2 = rf_read(e.rs2, wen, wa, wd);
    e.pc  = pc;
    e.pc4 = pc + 32'd4;
    return e;
  endfunction

  task automatic step(input logic [31:0] ins, input logic [31:0] pc,
                      input logic wen, input logic [4:0] wa, input logic [31:0] wd);
    exp_t e;
    InstrD = ins; PCD = pc; PCPlus4D = pc + 32'd4;
    RegWriteW = wen; RDW = wa; ResultW = wd;
    exp_q.push_back(model(ins, pc, wen, wa, wd));
    if (wen && wa != 5'd0) m_rf[wa] = wd;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_outputs(e);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
  endtask

  localparam logic [6:0] c_ops [6] = '{7'h03, 7'h23, 7'h33, 7'h63, 7'h13, 7'h37};

  initial begin
    logic [31:0] ins;
    rst = 1'b1;
    InstrD = '0; PCD = '0; PCPlus4D = '0; RegWriteW = 1'b0; RDW = '0; ResultW = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check_outputs('0);
    // Write attempted while held in reset must be dropped.
    RegWriteW = 1'b1; RDW = 5'd6; ResultW = 32'h1234;
    @(posedge clk);
    #1;
    check_outputs('0);
    rst = 1'b0;
    step(32'h006302B3, 32'h0, 1'b0, 5'd0, 32'd0);

    step(32'hA4A4A4A4, 32'h8, 1'b1, 5'd4, 32'd1);
    check("unk_imm", ImmExtE, 32'hFFFFFA4A);
    check("unk_rs1", {27'd0, RS1E}, 32'd9);
    step(32'h004202B3, 32'h10, 1'b0, 5'd0, 32'd0);
    check("add_rd1", RD1E, 32'd1);
    step(32'h004202B3, 32'h14, 1'b1, 5'd4, 32'h55);
    check("byp_rd2", RD2E, 32'h55);

    step(32'h000002B3, 32'h18, 1'b1, 5'd0, 32'hDEADBEEF);
    step(32'h000002B3, 32'h1C, 1'b0, 5'd0, 32'd0);
    check("x0_rd1", RD1E, 32'd0);

    step(32'h00500093, 32'h20, 1'b1, 5'd1, 32'h100);
    step(32'h402081B3, 32'h24, 1'b1, 5'd2, 32'h30);
    check("sub_alu", {29'd0, ALUControlE}, 32'd1);
    step(32'h0020A423, 32'h28, 1'b0, 5'd0, 32'd0);
    check("sw_imm", ImmExtE, 32'd8);
    step(32'h0040A183, 32'h2C, 1'b0, 5'd0, 32'd0);
    step(32'h0020A1B3, 32'h30, 1'b0, 5'd0, 32'd0);
    step(32'h0020E1B3, 32'h34, 1'b0, 5'd0, 32'd0);
    step(32'h0020F1B3, 32'h38, 1'b0, 5'd0, 32'd0);
    step(32'h002091B3, 32'h3C, 1'b0, 5'd0, 32'd0);
    step(32'hC0008193, 32'h40, 1'b0, 5'd0, 32'd0);
    step(32'hFE208EE3, 32'h44, 1'b0, 5'd0, 32'd0);
    check("beq_imm", ImmExtE, 32'hFFFFFFFC);

    for (int i = 0; i < 40; i++) begin
      ins = $urandom;
      ins[6:0] = c_ops[$urandom_range(0, 5)];
      step(ins, 32'($urandom) & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)), 32'($urandom));
    end

    // Asynchronous reset in the middle of a cycle.
    step(32'h402081B3, 32'h80, 1'b1, 5'd7, 32'h77);
    #2;
    rst = 1'b1;
    #1;
    clear_model();
    check_outputs('0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(32'h007383B3, 32'h84, 1'b0, 5'd0, 32'd0);
    check("post_rst_x7", RD1E, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
